axi_wr_burst_ctrl: RTL and testbench

Write-burst controller on the slave side of the AXI3 write path, directly downstream of the 2-entry address-channel FIFO. It pops one write-address entry at a time and walks the burst beat by beat. It generates the per-beat memory address for FIXED, INCR and WRAP bursts while accepting W-channel beats and driving a simple synchronous memory write port. After the last beat it returns one B response.

---
 rtl/axi_wr_burst_ctrl.sv | 142 ++++++++++++++
 tb/tb_axi_wr_burst_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_burst_ctrl.sv
// AXI3 slave write-burst controller: pops one address entry, walks FIXED/INCR/WRAP
// beats onto a synchronous memory write port, then returns a single B response.
module axi_wr_burst_ctrl #(
  parameter int TAGBITS = 2,
  parameter int ADDRW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [48+TAGBITS:0]  fifo_entry,
  output logic                 fifo_read_en,
  input  logic [TAGBITS-1:0]   wid,
  input  logic [ADDRW-1:0]     wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wlast,
  input  logic                 wvalid,
  output logic                 wready,
  output logic                 mem_we,
  output logic [ADDRW-1:0]     mem_addr,
  output logic [ADDRW-1:0]     mem_wdata,
  output logic [3:0]           mem_wstrb,
  output logic [TAGBITS-1:0]   bid,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t             state, state_nxt;
  logic [TAGBITS-1:0] id_q;
  logic [ADDRW-1:0]   addr_q, beat_addr, addr_nxt;
  logic [3:0]         len_q, beat_cnt;
  logic [1:0]         size_q, burst_q;
  logic               err, wlast_err;

  logic [TAGBITS-1:0] e_id;
  logic [ADDRW-1:0]   e_addr, e_mask;
  logic [3:0]         e_len;
  logic [1:0]         e_size, e_burst;
  logic               entry_err, pop, beat, last_beat, err_now;
  logic [ADDRW-1:0]   bytes, total, lower, incr_addr;
  logic               unused_entry_bits;

  assign e_id    = fifo_entry[48+TAGBITS:49];
  assign e_addr  = fifo_entry[48:17];
  assign e_len   = fifo_entry[16:13];
  assign e_size  = fifo_entry[12:11];
  assign e_burst = fifo_entry[10:9];
  // lock, cache and prot carry no meaning for this memory
  assign unused_entry_bits = ^fifo_entry[8:0];

  assign e_mask    = (ADDRW'(1) << e_size) - ADDRW'(1);
  assign entry_err = (e_burst == 2'b11) || (e_size == 2'b11) ||
                     ((e_burst == 2'b10) && !(e_len inside {4'd1, 4'd3, 4'd7, 4'd15})) ||
                     ((e_burst == 2'b10) && ((e_addr & e_mask) != '0));

  assign pop       = (state == IDLE) && !fifo_empty;
  assign beat      = (state == DATA) && wvalid;
  assign last_beat = (beat_cnt == len_q);
  assign err_now   = err || (wid != id_q);

  // Beat address generation; WRAP wraps back to the aligned window base
  assign bytes     = ADDRW'(1) << size_q;
  assign total     = bytes * (ADDRW'(len_q) + ADDRW'(1));
  assign lower     = addr_q & ~(total - ADDRW'(1));
  assign incr_addr = beat_addr + bytes;

  always_comb begin
    addr_nxt = beat_addr;
    case (burst_q)
      2'b01:   addr_nxt = (beat_addr & ~(bytes - ADDRW'(1))) + bytes;
      2'b10:   addr_nxt = (incr_addr == lower + total) ? lower : incr_addr;
      default: addr_nxt = beat_addr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    fifo_read_en = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    case (state)
      IDLE: begin
        fifo_read_en = !fifo_empty;
        if (!fifo_empty) state_nxt = DATA;
      end
      DATA: begin
        wready = 1'b1;
        if (wvalid && last_beat) state_nxt = RESP;
      end
      RESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= '0;
      addr_q    <= '0;
      beat_addr <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      wlast_err <= 1'b0;
    end else if (pop) begin
      id_q      <= e_id;
      addr_q    <= e_addr;
      beat_addr <= e_addr;
      len_q     <= e_len;
      size_q    <= e_size;
      burst_q   <= e_burst;
      beat_cnt  <= '0;
      err       <= entry_err;
      wlast_err <= 1'b0;
    end else if (beat) begin
      beat_cnt  <= beat_cnt + 4'd1;
      beat_addr <= addr_nxt;
      if (err_now) err <= 1'b1;
      // a misplaced wlast only poisons the response, it never blocks writes
      if (wlast != last_beat) wlast_err <= 1'b1;
    end
  end

  assign mem_we    = beat && !err_now;
  assign mem_addr  = beat_addr;
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb;
  assign bid       = id_q;
  assign bresp     = {err || wlast_err, 1'b0};

endmodule

// File: tb/tb_axi_wr_burst_ctrl.sv
// Directed bench for axi_wr_burst_ctrl: burst types, error responses, B backpressure
// and mid-burst reset, each checked against hand-computed values.
module tb_axi_wr_burst_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [50:0] fifo_entry;
  logic        fifo_read_en;
  logic [1:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  bid, bresp;
  logic        bvalid, bready;

  int total = 0;
  int bad   = 0;

  axi_wr_burst_ctrl #(.TAGBITS(2), .ADDRW(32)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_entry(fifo_entry),
    .fifo_read_en(fifo_read_en), .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [50:0] mk(input logic [1:0] id, input logic [31:0] a,
                                     input logic [3:0] len, input logic [1:0] size,
                                     input logic [1:0] burst);
    return {id, a, len, size, burst, 2'b01, 4'b1010, 3'b101};
  endfunction

  task automatic pop(input logic [50:0] e);
    @(negedge clk);
    fifo_entry = e;
    fifo_empty = 1'b0;
    #1;
    chk("pop_en", 32'(fifo_read_en), 32'd1);
    chk("pre_wready", 32'(wready), 32'd0);
    @(posedge clk);
    #1;
    fifo_empty = 1'b1;
    chk("wready_t1", 32'(wready), 32'd1);
    chk("no_pop_in_data", 32'(fifo_read_en), 32'd0);
  endtask

  task automatic beat(input string tag, input logic [1:0] w_id, input logic last,
                      input logic [31:0] exp_addr, input logic exp_we);
    @(negedge clk);
    wvalid = 1'b1;
    wid    = w_id;
    wlast  = last;
    wdata  = $urandom;
    wstrb  = 4'($urandom);
    #1;
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_we"}, 32'(mem_we), 32'(exp_we));
    chk({tag, "_wready"}, 32'(wready), 32'd1);
    chk({tag, "_wdata"}, mem_wdata, wdata);
    chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'(wstrb));
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic resp(input string tag, input logic [1:0] exp_id, input logic [1:0] exp_resp);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, "_bid"}, 32'(bid), 32'(exp_id));
    chk({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
    chk({tag, "_wready_off"}, 32'(wready), 32'd0);
    @(negedge clk);
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    chk({tag, "_bvalid_drop"}, 32'(bvalid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; fifo_empty = 1'b1; fifo_entry = '0; wid = '0; wdata = '0;
    wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    #1;
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rd_en", 32'(fifo_read_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // INCR aligned, with a stall cycle after beat 0
    pop(mk(2'd2, 32'h1000, 4'd3, 2'd2, 2'b01));
    beat("incr0", 2'd2, 1'b0, 32'h1000, 1'b1);
    @(negedge clk);
    #1;
    chk("stall_we", 32'(mem_we), 32'd0);
    chk("stall_addr", mem_addr, 32'h1004);
    beat("incr1", 2'd2, 1'b0, 32'h1004, 1'b1);
    beat("incr2", 2'd2, 1'b0, 32'h1008, 1'b1);
    beat("incr3", 2'd2, 1'b1, 32'h100C, 1'b1);
    resp("incr", 2'd2, 2'b00);

    // WRAP across a 16-byte window
    pop(mk(2'd1, 32'h1008, 4'd3, 2'd2, 2'b10));
    beat("wrap0", 2'd1, 1'b0, 32'h1008, 1'b1);
    beat("wrap1", 2'd1, 1'b0, 32'h100C, 1'b1);
    beat("wrap2", 2'd1, 1'b0, 32'h1000, 1'b1);
    beat("wrap3", 2'd1, 1'b1, 32'h1004, 1'b1);
    resp("wrap", 2'd1, 2'b00);

    // FIXED
    pop(mk(2'd0, 32'h2002, 4'd2, 2'd1, 2'b00));
    beat("fix0", 2'd0, 1'b0, 32'h2002, 1'b1);
    beat("fix1", 2'd0, 1'b0, 32'h2002, 1'b1);
    beat("fix2", 2'd0, 1'b1, 32'h2002, 1'b1);
    resp("fix", 2'd0, 2'b00);

    // INCR unaligned start realigns on the second beat
    pop(mk(2'd3, 32'h1001, 4'd1, 2'd2, 2'b01));
    beat("unal0", 2'd3, 1'b0, 32'h1001, 1'b1);
    beat("unal1", 2'd3, 1'b1, 32'h1004, 1'b1);
    resp("unal", 2'd3, 2'b00);

    // Reserved burst type: beats accepted, nothing written
    pop(mk(2'd1, 32'h1000, 4'd1, 2'd2, 2'b11));
    beat("rsv0", 2'd1, 1'b0, 32'h1000, 1'b0);
    @(negedge clk);
    wvalid = 1'b1; wid = 2'd1; wlast = 1'b1;
    #1;
    chk("rsv1_we", 32'(mem_we), 32'd0);
    chk("rsv1_wready", 32'(wready), 32'd1);
    @(posedge clk);
    #1;
    wvalid = 1'b0; wlast = 1'b0;
    resp("rsv", 2'd1, 2'b10);

    // Early wlast: data still written, response poisoned
    pop(mk(2'd2, 32'h3000, 4'd1, 2'd2, 2'b01));
    beat("early0", 2'd2, 1'b1, 32'h3000, 1'b1);
    beat("early1", 2'd2, 1'b1, 32'h3004, 1'b1);
    resp("early", 2'd2, 2'b10);

    // wid mismatch on the last beat only
    pop(mk(2'd3, 32'h4000, 4'd1, 2'd2, 2'b01));
    beat("wid0", 2'd3, 1'b0, 32'h4000, 1'b1);
    beat("wid1", 2'd0, 1'b1, 32'h4004, 1'b0);
    resp("wid", 2'd3, 2'b10);

    // Two queued entries with 5 cycles of B backpressure
    @(negedge clk);
    fifo_entry = mk(2'd1, 32'h5000, 4'd0, 2'd2, 2'b01);
    fifo_empty = 1'b0;
    #1;
    chk("bp_pop1", 32'(fifo_read_en), 32'd1);
    @(posedge clk);
    #1;
    fifo_entry = mk(2'd2, 32'h6000, 4'd0, 2'd2, 2'b01);
    chk("bp_no_pop_data", 32'(fifo_read_en), 32'd0);
    beat("bp_a", 2'd1, 1'b1, 32'h5000, 1'b1);
    chk("bp_bvalid", 32'(bvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_bvalid", 32'(bvalid), 32'd1);
      chk("bp_hold_bid", 32'(bid), 32'd1);
      chk("bp_hold_rd_en", 32'(fifo_read_en), 32'd0);
    end
    @(negedge clk);
    bready = 1'b1;
    #1;
    chk("bp_hs_rd_en", 32'(fifo_read_en), 32'd0);
    @(posedge clk);
    #1;
    bready = 1'b0;
    chk("bp_bvalid_drop", 32'(bvalid), 32'd0);
    chk("bp_pop2", 32'(fifo_read_en), 32'd1);
    @(posedge clk);
    #1;
    fifo_empty = 1'b1;
    chk("bp_wready2", 32'(wready), 32'd1);
    beat("bp_b", 2'd2, 1'b1, 32'h6000, 1'b1);
    resp("bp_b", 2'd2, 2'b00);

    // Reset in the middle of a burst
    pop(mk(2'd1, 32'h7000, 4'd3, 2'd2, 2'b01));
    beat("rb0", 2'd1, 1'b0, 32'h7000, 1'b1);
    @(negedge clk);
    wvalid = 1'b1; wid = 2'd1; wlast = 1'b0;
    #1;
    chk("rb1_we", 32'(mem_we), 32'd1);
    chk("rb1_addr", mem_addr, 32'h7004);
    rst = 1'b1;
    #1;
    chk("rb_wready", 32'(wready), 32'd0);
    chk("rb_mem_we", 32'(mem_we), 32'd0);
    chk("rb_bvalid", 32'(bvalid), 32'd0);
    chk("rb_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("rb_no_bresp", 32'(bvalid), 32'd0);
      chk("rb_idle", 32'(wready), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
